// File: rtl/fetch_queue_controller.sv
// Instruction-queue write-side sequencer: issues in-order imem fetches under a
// valid/grant handshake, statically predicts JAL and backward branches, pushes
// instruction/PC/prediction into the queue, reserves queue slots with credits
// so the queue never overflows, and discards wrong-path responses after a
// flush or a predicted-taken redirect.
module fetch_queue_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IQ_DEPTH = 8,
    parameter int unsigned MAX_OUT  = 4,
    localparam int unsigned CW      = $clog2(IQ_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_fetch_en,
    input  logic          i_flush,
    input  logic [31:0]   i_flush_pc,
    output logic          o_imem_req,
    output logic [31:0]   o_imem_addr,
    input  logic          i_imem_gnt,
    input  logic          i_imem_rvalid,
    input  logic [31:0]   i_imem_rdata,
    output logic          o_iq_wrt_en,
    output logic [31:0]   o_iq_wrt_data,
    output logic [31:0]   o_iq_wrt_inst_pc,
    output logic          o_iq_wrt_taken,
    output logic [31:0]   o_iq_wrt_target,
    input  logic          i_iq_pop,
    output logic [CW-1:0] o_credits
);

    localparam int unsigned OW = $clog2(MAX_OUT + 1);

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] credits_q, credits_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] drop_cnt_q, drop_cnt_d;

    logic          req;
    logic          fire;
    logic          drop;
    logic          push;
    logic          pred_taken;
    logic [31:0]   pred_target;
    logic [31:0]   imm_j;
    logic [31:0]   imm_b;
    logic [6:0]    opcode;

    // Request valid, response classification and static branch prediction.
    always_comb begin
        req    = (state_q == FETCH) && (credits_q != '0) &&
                 (outstanding_q < OW'(MAX_OUT)) && !i_flush;
        fire   = req && i_imem_gnt;
        drop   = i_imem_rvalid && ((drop_cnt_q != '0) || i_flush);
        push   = i_imem_rvalid && !drop;

        opcode = i_imem_rdata[6:0];
        imm_j  = {{11{i_imem_rdata[31]}}, i_imem_rdata[31], i_imem_rdata[19:12],
                  i_imem_rdata[20], i_imem_rdata[30:21], 1'b0};
        imm_b  = {{19{i_imem_rdata[31]}}, i_imem_rdata[31], i_imem_rdata[7],
                  i_imem_rdata[30:25], i_imem_rdata[11:8], 1'b0};

        pred_taken  = 1'b0;
        pred_target = resp_pc_q + 32'd4;
        if (opcode == OPC_JAL) begin
            pred_taken  = 1'b1;
            pred_target = resp_pc_q + imm_j;
        end else if ((opcode == OPC_BRANCH) && i_imem_rdata[31]) begin
            pred_taken  = 1'b1;
            pred_target = resp_pc_q + imm_b;
        end
    end

    // Output drive: queue write fields are forced to zero when not pushing.
    always_comb begin
        o_imem_req       = req;
        o_imem_addr      = fetch_pc_q;
        o_iq_wrt_en      = push;
        o_iq_wrt_data    = push ? i_imem_rdata : '0;
        o_iq_wrt_inst_pc = push ? resp_pc_q : '0;
        o_iq_wrt_taken   = push && pred_taken;
        o_iq_wrt_target  = push ? pred_target : '0;
        o_credits        = credits_q;
    end

    // Next-state computation: flush overrides redirect, redirect overrides
    // sequential fetch/response bookkeeping.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        credits_d     = credits_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q - OW'(i_imem_rvalid) + OW'(fire);

        if (i_flush) begin
            // Queue is emptied by the same flush, so only the responses
            // still to be discarded keep their reserved slots.
            fetch_pc_d = i_flush_pc;
            resp_pc_d  = i_flush_pc;
            drop_cnt_d = outstanding_q - OW'(i_imem_rvalid);
            credits_d  = CW'(IQ_DEPTH) - CW'(drop_cnt_d);
            if (drop_cnt_d != '0) begin
                state_d = DRAIN;
            end else begin
                state_d = i_fetch_en ? FETCH : IDLE;
            end
        end else begin
            credits_d = credits_q + CW'(i_iq_pop) + CW'(drop) - CW'(fire);

            if (fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end

            if (drop && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end

            if (push) begin
                resp_pc_d = pred_taken ? pred_target : resp_pc_q + 32'd4;
            end

            if (push && pred_taken) begin
                // Every request still in flight after this cycle, including
                // one granted right now, belongs to the wrong path.
                fetch_pc_d = pred_target;
                drop_cnt_d = outstanding_d;
            end

            case (state_q)
                IDLE:    if (i_fetch_en) state_d = FETCH;
                FETCH:   if (!i_fetch_en) state_d = IDLE;
                DRAIN: begin
                    if (drop_cnt_d == '0) begin
                        state_d = i_fetch_en ? FETCH : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (push && pred_taken && (drop_cnt_d != '0)) begin
                state_d = DRAIN;
            end
        end
    end

    // State and bookkeeping registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            credits_q     <= CW'(IQ_DEPTH);
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            credits_q     <= credits_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue_controller.sv
// Bench for fetch_queue_controller: two instances (8-deep/4-outstanding and
// 4-deep/2-outstanding) share stimulus; one is selected and reset per test.
module tb_fetch_queue_controller;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] JALM8 = 32'hFF9F_F06F;
    localparam logic [31:0] FWDBR = 32'h0020_8463;
    localparam logic [31:0] BEQM4 = 32'hFE00_0EE3;

    typedef struct {
        logic        en;
        logic        fl;
        logic [31:0] fpc;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        pop;
        logic        xreq;
        logic [31:0] xaddr;
        logic        xpush;
        logic [31:0] xpc;
        logic        xtk;
        logic [31:0] xtgt;
        int          xcred;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0, fl = 1'b0, gnt = 1'b0, rv = 1'b0, pop = 1'b0;
    logic [31:0] fpc = '0, rd = '0;

    logic        a_req, a_wen, a_tk, b_req, b_wen, b_tk;
    logic [31:0] a_addr, a_data, a_pc, a_tgt, b_addr, b_data, b_pc, b_tgt;
    logic [3:0]  a_cred;
    logic [2:0]  b_cred;

    logic        sel = 1'b0;
    logic        req, wen, tk;
    logic [31:0] addr, wdata, wpc, tgt, cred;

    int          errors = 0;
    int          checks = 0;
    string       tname = "";
    vec_t        tv[$];
    exp_t        sb[$];

    always #5 clk = ~clk;

    fetch_queue_controller #(.RESET_PC(32'h0), .IQ_DEPTH(8), .MAX_OUT(4)) u_a (
        .clk(clk), .rstn(rstn), .i_fetch_en(en), .i_flush(fl), .i_flush_pc(fpc),
        .o_imem_req(a_req), .o_imem_addr(a_addr), .i_imem_gnt(gnt),
        .i_imem_rvalid(rv), .i_imem_rdata(rd), .o_iq_wrt_en(a_wen),
        .o_iq_wrt_data(a_data), .o_iq_wrt_inst_pc(a_pc), .o_iq_wrt_taken(a_tk),
        .o_iq_wrt_target(a_tgt), .i_iq_pop(pop), .o_credits(a_cred)
    );

    fetch_queue_controller #(.RESET_PC(32'h0), .IQ_DEPTH(4), .MAX_OUT(2)) u_b (
        .clk(clk), .rstn(rstn), .i_fetch_en(en), .i_flush(fl), .i_flush_pc(fpc),
        .o_imem_req(b_req), .o_imem_addr(b_addr), .i_imem_gnt(gnt),
        .i_imem_rvalid(rv), .i_imem_rdata(rd), .o_iq_wrt_en(b_wen),
        .o_iq_wrt_data(b_data), .o_iq_wrt_inst_pc(b_pc), .o_iq_wrt_taken(b_tk),
        .o_iq_wrt_target(b_tgt), .i_iq_pop(pop), .o_credits(b_cred)
    );

    assign req   = sel ? b_req  : a_req;
    assign addr  = sel ? b_addr : a_addr;
    assign wen   = sel ? b_wen  : a_wen;
    assign wdata = sel ? b_data : a_data;
    assign wpc   = sel ? b_pc   : a_pc;
    assign tk    = sel ? b_tk   : a_tk;
    assign tgt   = sel ? b_tgt  : a_tgt;
    assign cred  = sel ? 32'(b_cred) : 32'(a_cred);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %h expected %h", tname, name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s/%s", tname, name);
    endtask

    function automatic vec_t mk(input logic e, f, input logic [31:0] fp, input logic g, r,
                                input logic [31:0] d, input logic p, xr,
                                input logic [31:0] xa, input logic xp,
                                input logic [31:0] xpc, input logic xt,
                                input logic [31:0] xtg, input int xc);
        vec_t v;
        v.en = e; v.fl = f; v.fpc = fp; v.gnt = g; v.rv = r; v.rd = d; v.pop = p;
        v.xreq = xr; v.xaddr = xa; v.xpush = xp; v.xpc = xpc; v.xtk = xt;
        v.xtgt = xtg; v.xcred = xc;
        return v;
    endfunction

    task automatic do_reset(input logic useb, input string name);
        tname = name;
        sel   = useb;
        rstn  = 1'b0;
        en = 1'b0; fl = 1'b0; gnt = 1'b0; rv = 1'b0; pop = 1'b0; fpc = '0; rd = '0;
        sb.delete();
        @(negedge clk);
        chk("rst_req", {31'b0, req}, 32'd0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_cred", cred, useb ? 32'd4 : 32'd8);
        chk("rst_wen", {31'b0, wen}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // Drive one cycle of stimulus (called at posedge+1), check at negedge.
    task automatic apply(input vec_t v);
        exp_t e;
        en = v.en; fl = v.fl; fpc = v.fpc; gnt = v.gnt; rv = v.rv; rd = v.rd; pop = v.pop;
        if (v.xpush) begin
            e.data = v.rd; e.pc = v.xpc; e.taken = v.xtk; e.target = v.xtgt;
            sb.push_back(e);
        end
        @(negedge clk);
        chk("req", {31'b0, req}, {31'b0, v.xreq});
        if (v.xreq) chk("addr", addr, v.xaddr);
        chk("credits", cred, 32'(v.xcred));
        if (wen) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_push");
            end else begin
                e = sb.pop_front();
                chk("push_data", wdata, e.data);
                chk("push_pc", wpc, e.pc);
                chk("push_taken", {31'b0, tk}, {31'b0, e.taken});
                chk("push_target", tgt, e.target);
            end
        end else if (sb.size() != 0) begin
            fail_now("missing_push");
            sb.delete(0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_table();
        for (int i = 0; i < tv.size(); i++) apply(tv[i]);
        tv.delete();
    endtask

    initial begin
        // Streaming NOP fetch, then stop and drain the queue by pops.
        do_reset(1'b0, "stream");
        tv.push_back(mk(1,0,0, 0,0,0,   0, 0,0,    0,0,0,0,    8));
        tv.push_back(mk(1,0,0, 1,0,0,   0, 1,0,    0,0,0,0,    8));
        tv.push_back(mk(1,0,0, 1,1,NOP, 0, 1,4,    1,0,0,4,    7));
        tv.push_back(mk(1,0,0, 1,1,NOP, 0, 1,8,    1,4,0,8,    6));
        tv.push_back(mk(1,0,0, 1,1,NOP, 1, 1,12,   1,8,0,12,   5));
        tv.push_back(mk(0,0,0, 0,1,NOP, 0, 1,16,   1,12,0,16,  5));
        tv.push_back(mk(0,0,0, 0,0,0,   1, 0,0,    0,0,0,0,    5));
        tv.push_back(mk(0,0,0, 0,0,0,   1, 0,0,    0,0,0,0,    6));
        tv.push_back(mk(0,0,0, 0,0,0,   1, 0,0,    0,0,0,0,    7));
        tv.push_back(mk(0,0,0, 0,0,0,   0, 0,0,    0,0,0,0,    8));
        run_table();

        // Credit exhaustion with a 4-entry queue; one pop frees one request.
        do_reset(1'b1, "credits");
        tv.push_back(mk(1,0,0, 0,0,0,   0, 0,0,    0,0,0,0,    4));
        tv.push_back(mk(1,0,0, 1,0,0,   0, 1,0,    0,0,0,0,    4));
        tv.push_back(mk(1,0,0, 1,1,NOP, 0, 1,4,    1,0,0,4,    3));
        tv.push_back(mk(1,0,0, 1,1,NOP, 0, 1,8,    1,4,0,8,    2));
        tv.push_back(mk(1,0,0, 1,1,NOP, 0, 1,12,   1,8,0,12,   1));
        tv.push_back(mk(1,0,0, 1,1,NOP, 0, 0,0,    1,12,0,16,  0));
        tv.push_back(mk(1,0,0, 1,0,0,   0, 0,0,    0,0,0,0,    0));
        tv.push_back(mk(1,0,0, 1,0,0,   1, 0,0,    0,0,0,0,    0));
        tv.push_back(mk(1,0,0, 1,0,0,   0, 1,16,   0,0,0,0,    1));
        tv.push_back(mk(1,0,0, 1,1,NOP, 0, 0,0,    1,16,0,20,  0));
        tv.push_back(mk(0,0,0, 0,0,0,   0, 0,0,    0,0,0,0,    0));
        run_table();

        // Outstanding limit of 2; one response allows one more request.
        do_reset(1'b1, "max_out");
        tv.push_back(mk(1,0,0, 0,0,0,   0, 0,0,    0,0,0,0,    4));
        tv.push_back(mk(1,0,0, 1,0,0,   0, 1,0,    0,0,0,0,    4));
        tv.push_back(mk(1,0,0, 1,0,0,   0, 1,4,    0,0,0,0,    3));
        tv.push_back(mk(1,0,0, 1,0,0,   0, 0,0,    0,0,0,0,    2));
        tv.push_back(mk(1,0,0, 1,0,0,   0, 0,0,    0,0,0,0,    2));
        tv.push_back(mk(1,0,0, 1,1,NOP, 0, 0,0,    1,0,0,4,    2));
        tv.push_back(mk(1,0,0, 1,0,0,   0, 1,8,    0,0,0,0,    2));
        tv.push_back(mk(1,0,0, 1,0,0,   0, 0,0,    0,0,0,0,    1));
        tv.push_back(mk(1,0,0, 0,1,NOP, 0, 0,0,    1,4,0,8,    1));
        tv.push_back(mk(1,0,0, 0,1,NOP, 0, 1,12,   1,8,0,12,   1));
        tv.push_back(mk(0,0,0, 0,0,0,   0, 1,12,   0,0,0,0,    1));
        tv.push_back(mk(0,0,0, 0,0,0,   0, 0,0,    0,0,0,0,    1));
        run_table();

        // Flush with 3 outstanding and a response in the flush cycle.
        do_reset(1'b0, "flush");
        tv.push_back(mk(1,0,0,     0,0,0,   0, 0,0,      0,0,0,0,          8));
        tv.push_back(mk(1,0,0,     1,0,0,   0, 1,0,      0,0,0,0,          8));
        tv.push_back(mk(1,0,0,     1,0,0,   0, 1,4,      0,0,0,0,          7));
        tv.push_back(mk(1,0,0,     1,0,0,   0, 1,8,      0,0,0,0,          6));
        tv.push_back(mk(1,1,'h100, 1,1,NOP, 0, 0,0,      0,0,0,0,          5));
        tv.push_back(mk(1,0,0,     1,1,NOP, 0, 0,0,      0,0,0,0,          6));
        tv.push_back(mk(1,0,0,     1,1,NOP, 0, 0,0,      0,0,0,0,          7));
        tv.push_back(mk(1,0,0,     1,0,0,   0, 1,'h100,  0,0,0,0,          8));
        tv.push_back(mk(1,0,0,     0,1,NOP, 0, 1,'h104,  1,'h100,0,'h104,  7));
        tv.push_back(mk(0,0,0,     0,0,0,   1, 1,'h104,  0,0,0,0,          7));
        tv.push_back(mk(0,0,0,     0,0,0,   0, 0,0,      0,0,0,0,          8));
        run_table();

        // JAL -8 redirect with grant in the same cycle, forward and backward branches.
        do_reset(1'b0, "predict");
        tv.push_back(mk(1,1,'h20, 0,0,0,     0, 0,0,     0,0,0,0,           8));
        tv.push_back(mk(1,0,0,    1,0,0,     0, 1,'h20,  0,0,0,0,           8));
        tv.push_back(mk(1,0,0,    1,0,0,     0, 1,'h24,  0,0,0,0,           7));
        tv.push_back(mk(1,0,0,    1,1,JALM8, 0, 1,'h28,  1,'h20,1,'h18,     6));
        tv.push_back(mk(1,0,0,    1,1,NOP,   0, 0,0,     0,0,0,0,           5));
        tv.push_back(mk(1,0,0,    1,1,NOP,   0, 0,0,     0,0,0,0,           6));
        tv.push_back(mk(1,0,0,    1,0,0,     0, 1,'h18,  0,0,0,0,           7));
        tv.push_back(mk(1,0,0,    0,1,FWDBR, 0, 1,'h1C,  1,'h18,0,'h1C,     6));
        tv.push_back(mk(1,0,0,    1,0,0,     0, 1,'h1C,  0,0,0,0,           6));
        tv.push_back(mk(1,0,0,    0,1,BEQM4, 0, 1,'h20,  1,'h1C,1,'h18,     5));
        tv.push_back(mk(1,0,0,    0,0,0,     0, 1,'h18,  0,0,0,0,           5));
        run_table();

        // Asynchronous reset in the middle of fetching with 2 outstanding.
        do_reset(1'b0, "async_rst");
        tv.push_back(mk(1,0,0, 0,0,0, 0, 0,0, 0,0,0,0, 8));
        tv.push_back(mk(1,0,0, 1,0,0, 0, 1,0, 0,0,0,0, 8));
        tv.push_back(mk(1,0,0, 1,0,0, 0, 1,4, 0,0,0,0, 7));
        run_table();
        en = 1'b1; gnt = 1'b0;
        #1;
        chk("pre_rst_req", {31'b0, req}, 32'd1);
        chk("pre_rst_addr", addr, 32'h8);
        rstn = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, req}, 32'd0);
        chk("mid_rst_addr", addr, 32'h0);
        chk("mid_rst_cred", cred, 32'd8);
        chk("mid_rst_wen", {31'b0, wen}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
        tv.push_back(mk(1,0,0, 0,0,0, 0, 0,0, 0,0,0,0, 8));
        tv.push_back(mk(1,0,0, 1,0,0, 0, 1,0, 0,0,0,0, 8));
        tv.push_back(mk(1,0,0, 0,0,0, 0, 1,4, 0,0,0,0, 7));
        run_table();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
